dg0040_pc_sequencer: RTL
========================

# dg0040_pc_sequencer

Program-counter and call/return sequencer that drives the DG0040 5-deep return-address shift-register stack. It owns the 10-bit polynomial program counter, issues one-cycle push/pop commands on the stack's MODE1/MODE0 lines, and reloads PC from the stack's SP output on return. It also tracks stack depth so that silent overflow or underflow is flagged to the control unit.

## Interface
Parameters:
- PC_RESET, 10'h000, PC value loaded on reset.
- STACK_DEPTH, 5, number of stack levels; must match the shift-register stack.

Ports:
- CLK  in  1  system clock; also clocks the shift-register stack.
- NRESET  in  1  asynchronous, active-low reset.
- EXEC  in  1  instruction strobe; OP and TGT are valid when it is high.
- OP  in  2  operation: 00 next, 01 jump, 10 call, 11 return.
- TGT  in  10  jump/call target address.
- SP  in  10  top of stack from the shift-register stack.
- CLR_FLAGS  in  1  clears OVF and UNF.
- PC  out  10  program counter; also drives the stack's PC input.
- MODE1, MODE0  out  1 each  stack command: 00 hold, 10 push, 11 pop.
- BUSY  out  1  high while a call or return is completing.
- DEPTH  out  3  number of valid stack entries, 0..STACK_DEPTH.
- OVF, UNF  out  1 each  sticky overflow and underflow flags.

## Operation
- Polynomial increment: poly(PC) = {PC[9:6], ~(PC[0]^PC[1]), PC[5:1]}.
  - Page bits PC[9:6] never change on increment.
  - The low 6 bits form a maximal-length sequence with period 63.
  - Low bits 6'b111111 form a lockup state; poly() leaves them unchanged.
- FSM states: IDLE, PUSH, POP.
- EXEC is sampled only in IDLE. Any EXEC in PUSH or POP is ignored with no side effects.
- IDLE, OP=00: PC <= poly(PC).
- IDLE, OP=01: PC <= TGT.
- IDLE, OP=10 (call): PC <= poly(PC), which is the return address. Latch TGT, MODE <= 10, go to PUSH.
- PUSH: the stack captures PC at the edge that ends this cycle. PC <= latched TGT, MODE <= 00, go to IDLE. DEPTH increments, saturating at STACK_DEPTH.
- IDLE, OP=11 (return): PC <= SP, MODE <= 11, go to POP.
- POP: the stack shifts at the edge that ends this cycle. MODE <= 00, go to IDLE. DEPTH decrements, saturating at 0.
- Overflow: a call at DEPTH=STACK_DEPTH still pushes (oldest entry lost). DEPTH stays at STACK_DEPTH and OVF is set.
- Underflow: a return at DEPTH=0 still loads PC from SP. DEPTH stays 0 and UNF is set.
- CLR_FLAGS clears OVF and UNF. If a set and CLR_FLAGS occur in the same cycle, the set wins.
- Reset mid-operation (any state) returns immediately to IDLE with MODE=00, so no partial push or pop is issued after reset.

## Timing
- Reset values: PC=PC_RESET, MODE1=0, MODE0=0, BUSY=0, DEPTH=0, OVF=0, UNF=0, state IDLE.
- All outputs are registered.
- Latency:
  - next and jump: 1 cycle.
  - call: 2 cycles. PC shows the return address for exactly one cycle, with MODE=10, then shows TGT.
  - return: 2 cycles. PC=SP is visible one cycle after EXEC; BUSY is high for 1 cycle.
- MODE is never non-00 for two consecutive cycles.
- BUSY equals (state != IDLE).
- DEPTH and flags update at the same edge that MODE returns to 00.

## Configuration
- DG0040_SEQ_GUARD_EN defined:
  - A call at DEPTH=STACK_DEPTH is refused: no push, PC <= poly(PC), OVF set, no BUSY cycle.
  - A return at DEPTH=0 is refused: no pop, PC <= poly(PC), UNF set, no BUSY cycle.
- DG0040_SEQ_GUARD_EN undefined: overflow and underflow are lossy as described under Operation, and the flags are informative only.

## Test plan
- Reset, then 63 consecutive EXEC/OP=00 from PC=10'h000 → low 6 bits visit 63 distinct values and return to 6'h00; PC[9:6] stays 0. Separately, from PC=10'h03F, OP=00 → PC stays 10'h03F.
- PC=10'h100, call TGT=10'h2A5 → next cycle PC=poly(10'h100)=10'h120 with MODE=10 and BUSY=1. The following cycle PC=10'h2A5, MODE=00, DEPTH=1. A stack model's SP reads 10'h120.
- Nested calls to 10'h010, 10'h020, 10'h030, then three returns → PC sequence matches the pushed return addresses in LIFO order. DEPTH goes 3→0 and both flags stay 0.
- Six calls in a row → DEPTH saturates at 5 and OVF=1. With the guard macro, the sixth call leaves PC=poly(PC) and the stack model unchanged.
- Return at DEPTH=0 → UNF=1. CLR_FLAGS asserted in the same cycle as a second underflowing return → UNF remains 1.
- Assert NRESET low during a PUSH cycle → MODE=00, PC=PC_RESET, DEPTH=0 asynchronously, and no push is recorded by the stack model.

Source files
------------

// File: rtl/dg0040_pc_sequencer.sv
// Program-counter / call-return sequencer for the DG0040 5-deep shift-register stack.
// Optional macro DG0040_SEQ_GUARD_EN refuses overflowing calls and underflowing returns.
module dg0040_pc_sequencer #(
    parameter logic [9:0] PC_RESET    = 10'h000,
    parameter int         STACK_DEPTH = 5
) (
    input  logic       CLK,
    input  logic       NRESET,
    input  logic       EXEC,
    input  logic [1:0] OP,
    input  logic [9:0] TGT,
    input  logic [9:0] SP,
    input  logic       CLR_FLAGS,
    output logic [9:0] PC,
    output logic       MODE1,
    output logic       MODE0,
    output logic       BUSY,
    output logic [2:0] DEPTH,
    output logic       OVF,
    output logic       UNF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_POP  = 2'd2
    } state_t;

    localparam logic [1:0] OP_NEXT = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_PUSH = 2'b10;
    localparam logic [1:0] MODE_POP  = 2'b11;

    localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

    state_t     state_q, state_d;
    logic [9:0] pc_q, pc_d;
    logic [9:0] tgt_q, tgt_d;
    logic [1:0] mode_q, mode_d;
    logic       busy_q, busy_d;
    logic [2:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       ovf_set, unf_set;
    logic       call_ok, ret_ok;

    // Page bits are held; low 6 bits step a period-63 sequence (6'h3F locks up).
    function automatic logic [9:0] poly(input logic [9:0] p);
        return {p[9:6], ~(p[0] ^ p[1]), p[5:1]};
    endfunction

    always_comb begin
`ifdef DG0040_SEQ_GUARD_EN
        call_ok = (depth_q != DEPTH_MAX);
        ret_ok  = (depth_q != 3'd0);
`else
        call_ok = 1'b1;
        ret_ok  = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        mode_d  = MODE_HOLD;
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (EXEC) begin
                    case (OP)
                        OP_NEXT: pc_d = poly(pc_q);
                        OP_JUMP: pc_d = TGT;
                        OP_CALL: begin
                            pc_d = poly(pc_q);
                            if (call_ok) begin
                                tgt_d   = TGT;
                                mode_d  = MODE_PUSH;
                                state_d = S_PUSH;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                        default: begin
                            if (ret_ok) begin
                                pc_d    = SP;
                                mode_d  = MODE_POP;
                                state_d = S_POP;
                            end else begin
                                pc_d    = poly(pc_q);
                                unf_set = 1'b1;
                            end
                        end
                    endcase
                end
            end
            // Stack captures the return address at the edge ending this cycle.
            S_PUSH: begin
                pc_d    = tgt_q;
                state_d = S_IDLE;
                if (depth_q == DEPTH_MAX) ovf_set = 1'b1;
                else                      depth_d = depth_q + 3'd1;
            end
            S_POP: begin
                state_d = S_IDLE;
                if (depth_q == 3'd0) unf_set = 1'b1;
                else                 depth_d = depth_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
        // A set in the same cycle as a clear wins.
        ovf_d  = ovf_set | (ovf_q & ~CLR_FLAGS);
        unf_d  = unf_set | (unf_q & ~CLR_FLAGS);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            tgt_q   <= 10'h000;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign PC    = pc_q;
    assign MODE1 = mode_q[1];
    assign MODE0 = mode_q[0];
    assign BUSY  = busy_q;
    assign DEPTH = depth_q;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;

endmodule
